// File: rtl/gpu_pixel_writer.sv
// gpu_pixel_writer: turns a per-cycle (x, y, colour) pixel stream into
// single-word framebuffer writes with a req/ack handshake. A small FIFO
// absorbs memory stalls. Off-screen pixels are discarded and flagged.
module gpu_pixel_writer #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int CHANNEL_BITS = 8,
    parameter int ADDR_BITS    = 19,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pixel_valid_i,
    input  logic [WIDTH_BITS-1:0]     x_i,
    input  logic [HEIGHT_BITS-1:0]    y_i,
    input  logic [CHANNEL_BITS-1:0]   r_i,
    input  logic [CHANNEL_BITS-1:0]   g_i,
    input  logic [CHANNEL_BITS-1:0]   b_i,
    output logic                      pixel_ready_o,
    output logic                      mem_we_o,
    output logic [ADDR_BITS-1:0]      mem_addr_o,
    output logic [3*CHANNEL_BITS-1:0] mem_data_o,
    input  logic                      mem_ack_i,
    output logic                      drop_o,
    output logic                      idle_o,
    output logic [ADDR_BITS:0]        written_count_o
);

    localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int DATA_BITS  = 3 * CHANNEL_BITS;
    localparam int ENTRY_BITS = ADDR_BITS + DATA_BITS;

    localparam logic [WIDTH_BITS:0]  X_LIMIT = (WIDTH_BITS + 1)'(WIDTH);
    localparam logic [HEIGHT_BITS:0] Y_LIMIT = (HEIGHT_BITS + 1)'(HEIGHT);
    localparam logic [ADDR_BITS-1:0] ROW_PITCH = ADDR_BITS'(WIDTH);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                state, next_state;
    logic [ENTRY_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_BITS:0]     wr_ptr, rd_ptr;
    logic                  fifo_empty, fifo_full;
    logic                  in_range, accept, push, pop;
    logic [ADDR_BITS-1:0]  pix_addr;
    logic [ENTRY_BITS-1:0] head;

    // Pointers carry one wrap bit: equal means empty, differing only in the
    // wrap bit means full.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr ^ rd_ptr) == {1'b1, {PTR_BITS{1'b0}}});

    // Ready depends only on registered FIFO state, never on mem_ack_i.
    assign pixel_ready_o = !fifo_full;
    assign accept        = pixel_valid_i && pixel_ready_o;
    assign in_range      = ({1'b0, x_i} < X_LIMIT) && ({1'b0, y_i} < Y_LIMIT);
    assign push          = accept && in_range;

    // In-range pixels always fit in ADDR_BITS, so this cannot truncate.
    assign pix_addr = ADDR_BITS'(y_i) * ROW_PITCH + ADDR_BITS'(x_i);
    assign head     = fifo_mem[rd_ptr[PTR_BITS-1:0]];

    assign mem_we_o = (state == WRITE);
    assign idle_o   = (state == IDLE) && fifo_empty;

    // FIFO storage: written on push, contents need no reset.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[PTR_BITS-1:0]] <= {pix_addr, r_i, g_i, b_i};
    end

    // FIFO pointers; push and pop in the same cycle both advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Drop flag: one pulse per accepted off-screen pixel.
    always_ff @(posedge clk) begin
        if (rst) drop_o <= 1'b0;
        else     drop_o <= accept && !in_range;
    end

    // Write FSM next-state and pop decision.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (mem_ack_i) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // FSM state register plus the held write address/data and completion count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            mem_addr_o      <= '0;
            mem_data_o      <= '0;
            written_count_o <= '0;
        end else begin
            state <= next_state;
            if (pop) begin
                mem_addr_o <= head[ENTRY_BITS-1 -: ADDR_BITS];
                mem_data_o <= head[DATA_BITS-1:0];
            end
            if (state == WRITE && mem_ack_i)
                written_count_o <= written_count_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Directed bench for gpu_pixel_writer: table of single pixels plus
// hand-written stall, streaming and reset sequences.
module tb_gpu_pixel_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pixel_valid_i;
    logic [9:0]  x_i;
    logic [8:0]  y_i;
    logic [7:0]  r_i, g_i, b_i;
    logic        pixel_ready_o;
    logic        mem_we_o;
    logic [18:0] mem_addr_o;
    logic [23:0] mem_data_o;
    logic        mem_ack_i;
    logic        drop_o;
    logic        idle_o;
    logic [19:0] written_count_o;

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_count = '0;

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [7:0]  r, g, b;
        logic        drop;
        logic [18:0] addr;
        logic [23:0] data;
    } vec_t;

    vec_t vecs [6];

    gpu_pixel_writer dut (
        .clk             (clk),
        .rst             (rst),
        .pixel_valid_i   (pixel_valid_i),
        .x_i             (x_i),
        .y_i             (y_i),
        .r_i             (r_i),
        .g_i             (g_i),
        .b_i             (b_i),
        .pixel_ready_o   (pixel_ready_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_data_o      (mem_data_o),
        .mem_ack_i       (mem_ack_i),
        .drop_o          (drop_o),
        .idle_o          (idle_o),
        .written_count_o (written_count_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_pix(input logic [9:0] x, input logic [8:0] y,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        pixel_valid_i = 1'b1;
        x_i = x; y_i = y; r_i = r; g_i = g; b_i = b;
    endtask

    // One pixel in; for on-screen pixels the write is acked on its second cycle.
    task automatic apply_vec(input vec_t v);
        set_pix(v.x, v.y, v.r, v.g, v.b);
        tick();
        pixel_valid_i = 1'b0;
        chk("accept_drop", 32'(drop_o), 32'(v.drop));
        chk("accept_we", 32'(mem_we_o), 32'd0);
        tick();
        if (v.drop) begin
            chk("drop_clear", 32'(drop_o), 32'd0);
            chk("drop_we", 32'(mem_we_o), 32'd0);
            chk("drop_count", 32'(written_count_o), 32'(exp_count));
        end else begin
            chk("we_latency", 32'(mem_we_o), 32'd1);
            chk("addr", 32'(mem_addr_o), 32'(v.addr));
            chk("data", 32'(mem_data_o), 32'(v.data));
            tick();
            chk("we_hold", 32'(mem_we_o), 32'd1);
            chk("addr_hold", 32'(mem_addr_o), 32'(v.addr));
            mem_ack_i = 1'b1;
            tick();
            mem_ack_i = 1'b0;
            exp_count = exp_count + 1'b1;
            chk("count", 32'(written_count_o), 32'(exp_count));
            chk("we_done", 32'(mem_we_o), 32'd0);
            chk("idle_done", 32'(idle_o), 32'd1);
        end
    endtask

    initial begin
        vecs[0] = '{x:10'd3,   y:9'd2,   r:8'h11, g:8'h22, b:8'h33, drop:1'b0, addr:19'd1283,   data:24'h112233};
        vecs[1] = '{x:10'd639, y:9'd479, r:8'hff, g:8'h00, b:8'h80, drop:1'b0, addr:19'd307199, data:24'hff0080};
        vecs[2] = '{x:10'd0,   y:9'd0,   r:8'h01, g:8'h02, b:8'h03, drop:1'b0, addr:19'd0,      data:24'h010203};
        vecs[3] = '{x:10'd640, y:9'd0,   r:8'haa, g:8'hbb, b:8'hcc, drop:1'b1, addr:19'd0,      data:24'h0};
        vecs[4] = '{x:10'd0,   y:9'd480, r:8'haa, g:8'hbb, b:8'hcc, drop:1'b1, addr:19'd0,      data:24'h0};
        vecs[5] = '{x:10'd100, y:9'd50,  r:8'ha1, g:8'hb2, b:8'hc3, drop:1'b0, addr:19'd32100,  data:24'ha1b2c3};

        rst = 1'b1; pixel_valid_i = 1'b0; mem_ack_i = 1'b0;
        x_i = '0; y_i = '0; r_i = '0; g_i = '0; b_i = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_data", 32'(mem_data_o), 32'd0);
        chk("rst_drop", 32'(drop_o), 32'd0);
        chk("rst_count", 32'(written_count_o), 32'd0);
        chk("rst_ready", 32'(pixel_ready_o), 32'd1);
        chk("rst_idle", 32'(idle_o), 32'd1);

        // Ack while idle must not count as a write.
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk("ack_idle_count", 32'(written_count_o), 32'd0);

        for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

        // Back-to-back off-screen pixels give back-to-back drop pulses.
        set_pix(10'd640, 9'd0, 8'h0, 8'h0, 8'h0);
        tick();
        chk("drop2_first", 32'(drop_o), 32'd1);
        set_pix(10'd0, 9'd480, 8'h0, 8'h0, 8'h0);
        tick();
        pixel_valid_i = 1'b0;
        chk("drop2_second", 32'(drop_o), 32'd1);
        tick();
        chk("drop2_end", 32'(drop_o), 32'd0);
        chk("drop2_count", 32'(written_count_o), 32'(exp_count));

        // Stall: ack low, six pixels offered, five fit (one in WRITE + four queued).
        for (int i = 0; i < 6; i++) begin
            set_pix(10'(10 + i), 9'd5, 8'(i), 8'h0, 8'h0);
            chk($sformatf("stall_ready%0d", i), 32'(pixel_ready_o), (i < 5) ? 32'd1 : 32'd0);
            tick();
        end
        pixel_valid_i = 1'b0;
        chk("stall_we", 32'(mem_we_o), 32'd1);
        chk("stall_full", 32'(pixel_ready_o), 32'd0);
        mem_ack_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("drain_we%0d", k), 32'(mem_we_o), 32'd1);
            chk($sformatf("drain_addr%0d", k), 32'(mem_addr_o), 32'(3200 + 10 + k));
            if (k > 0) chk($sformatf("drain_ready%0d", k), 32'(pixel_ready_o), 32'd1);
            tick();
        end
        mem_ack_i = 1'b0;
        exp_count = exp_count + 20'd5;
        chk("drain_done_we", 32'(mem_we_o), 32'd0);
        chk("drain_count", 32'(written_count_o), 32'(exp_count));

        // 16-pixel row with ack held high: one write per cycle, never backpressured.
        begin
            int n, first_j, last_j;
            logic ready_low;
            n = 0; first_j = -1; last_j = -1; ready_low = 1'b0;
            mem_ack_i = 1'b1;
            for (int j = 0; j < 20; j++) begin
                if (j < 16) begin
                    set_pix(10'(j), 9'd7, 8'h55, 8'(j), 8'h66);
                    if (!pixel_ready_o) ready_low = 1'b1;
                end else begin
                    pixel_valid_i = 1'b0;
                end
                tick();
                if (mem_we_o) begin
                    chk($sformatf("row_addr%0d", n), 32'(mem_addr_o), 32'(7 * 640 + n));
                    if (first_j < 0) first_j = j;
                    last_j = j;
                    n++;
                end
            end
            mem_ack_i = 1'b0;
            exp_count = exp_count + 20'd16;
            chk("row_writes", 32'(n), 32'd16);
            chk("row_contiguous", 32'(last_j - first_j), 32'd15);
            chk("row_ready_low", 32'(ready_low), 32'd0);
            chk("row_count", 32'(written_count_o), 32'(exp_count));
        end

        // Reset mid-write with three entries queued.
        for (int i = 0; i < 4; i++) begin
            set_pix(10'(20 + i), 9'd1, 8'h0, 8'h0, 8'h0);
            tick();
        end
        pixel_valid_i = 1'b0;
        chk("pre_rst_we", 32'(mem_we_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_count = '0;
        chk("mid_rst_we", 32'(mem_we_o), 32'd0);
        chk("mid_rst_idle", 32'(idle_o), 32'd1);
        chk("mid_rst_count", 32'(written_count_o), 32'd0);
        tick();
        chk("post_rst_idle", 32'(idle_o), 32'd1);
        apply_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpu_pixel_writer.md
# gpu_pixel_writer

Downstream stage of the rectangle-fill walker: consumes the per-cycle (x, y) pixel coordinate stream plus a colour, converts each coordinate into a linear framebuffer address, and issues single-word writes to the framebuffer memory port with a req/ack handshake. A small FIFO decouples the one-pixel-per-cycle generator from a memory that may stall. Out-of-screen coordinates are dropped and flagged, never written.

## Interface

Parameters:
- WIDTH, 640, screen width in pixels
- HEIGHT, 480, screen height in pixels
- WIDTH_BITS, 10, x coordinate width
- HEIGHT_BITS, 9, y coordinate width
- CHANNEL_BITS, 8, bits per colour channel
- ADDR_BITS, 19, framebuffer word address width (must hold WIDTH*HEIGHT-1)
- FIFO_DEPTH, 4, entries in the pixel FIFO (power of two, ≥2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pixel_valid_i  in  1  pixel present on x_i/y_i/colour inputs this cycle
- x_i  in  WIDTH_BITS  pixel column
- y_i  in  HEIGHT_BITS  pixel row
- r_i, g_i, b_i  in  CHANNEL_BITS each  pixel colour
- pixel_ready_o  out  1  writer can accept a pixel this cycle
- mem_we_o  out  1  write request to framebuffer
- mem_addr_o  out  ADDR_BITS  write address
- mem_data_o  out  3*CHANNEL_BITS  write data, {r, g, b}, r in MSBs
- mem_ack_i  in  1  memory accepted the current write
- drop_o  out  1  one-cycle pulse: accepted pixel was off-screen and discarded
- idle_o  out  1  FIFO empty and no write outstanding
- written_count_o  out  ADDR_BITS+1  writes completed since reset, wraps modulo 2^(ADDR_BITS+1)

## Operation

- Accept: push occurs when pixel_valid_i && pixel_ready_o. pixel_ready_o = !fifo_full (registered state only; no combinational dependence on mem_ack_i).
- Range check at accept: if x_i ≥ WIDTH or y_i ≥ HEIGHT, pixel is not pushed; drop_o = 1 the following cycle. Otherwise push {addr, r, g, b}.
- Address: addr = y_i*WIDTH + x_i, computed in ADDR_BITS unsigned arithmetic before push; no truncation possible for in-range pixels.
- FIFO: circular buffer, FIFO_DEPTH entries, read/write pointers with one extra wrap bit; full when pointers differ only in wrap bit, empty when equal.
- Write FSM, two states:
  - IDLE: mem_we_o = 0. If FIFO non-empty: load head into mem_addr_o/mem_data_o, pop, go WRITE.
  - WRITE: mem_we_o = 1, address/data held stable. On mem_ack_i: increment written_count_o; if FIFO non-empty load next head, pop, stay WRITE (back-to-back); else go IDLE.
- Push and pop in the same cycle are both honoured; occupancy unchanged.
- idle_o = (state == IDLE) && fifo_empty.
- Upstream may present pixel_valid_i continuously; pixels refused (ready low) are the upstream's responsibility to hold.

## Timing

- Reset (rst high at a rising edge): state IDLE, FIFO empty, mem_we_o = 0, mem_addr_o = 0, mem_data_o = 0, drop_o = 0, written_count_o = 0, pixel_ready_o = 1, idle_o = 1. Reset mid-write abandons the outstanding write and all FIFO contents; mem_we_o low from the cycle after the reset edge.
- Latency: pixel accepted at edge N → mem_we_o high with its address/data after edge N+1 (FIFO write at N, FSM load at N+1).
- Throughput: one write per cycle when mem_ack_i is held high and FIFO non-empty.
- mem_ack_i ignored while mem_we_o = 0.
- drop_o asserted exactly one cycle per dropped pixel; consecutive drops give consecutive pulses.
- Full: with FIFO_DEPTH entries and WRITE stalled, pixel_ready_o = 0; pixel_ready_o returns high the cycle after the pop that frees a slot.

## Test plan

- Single pixel (x=3, y=2, rgb=0x11/0x22/0x33), ack after 2 cycles → mem_we_o high 1 cycle after accept, mem_addr_o=1283, mem_data_o=0x112233, written_count_o=1, idle_o=1 after ack.
- Corner pixel (639, 479) → mem_addr_o=307199; (0,0) → 0.
- Off-screen (x=640, y=0) and (x=0, y=480) → no write, drop_o pulses twice, written_count_o unchanged.
- mem_ack_i held low, 6 consecutive valid pixels → 1 in WRITE + 4 in FIFO, pixel_ready_o low after fifth accept; release ack high → 5 writes in 5 consecutive cycles, addresses in order.
- 16-pixel row stream with mem_ack_i held high → 16 back-to-back writes, pixel_ready_o never low, written_count_o=16.
- rst asserted while WRITE with 3 entries queued → next cycle mem_we_o=0, idle_o=1, written_count_o=0; a new pixel afterwards is written normally.
